log_reader: RTL and testbench

- Read-side companion to the violation logger: drains the 37-bit violation log RAM and streams it out as a byte stream with a valid/ready handshake.
- Typical sinks are a debug UART or an attestation-report buffer.
- Sits beside the logger on the RAM read port (re/rd_addr/rd_data). Drives a one-cycle clear request when a dump completes, if asked to.

---
 rtl/log_reader.sv | 218 +++++++++++++++++++++
 tb/tb_log_reader.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/log_reader.sv
// log_reader: drains the violation log RAM and streams it as bytes over valid/ready.
// Frame: HDR_BYTE, count[7:0], count[15:8], then each entry least-significant byte first.
module log_reader #(
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       DATA_W   = 37,
  parameter logic [ADDR_W-1:0] DEPTH    = 16'd256,
  parameter logic [7:0]        HDR_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              dump_req,
  input  logic              dump_abort,
  input  logic [ADDR_W-1:0] log_count,
  input  logic              clr_after,
  output logic              re,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_last,
  output logic              busy,
  output logic              done,
  output logic              clr_ram
);
  localparam int unsigned       NBYTES  = (DATA_W + 7) / 8;
  localparam int unsigned       ENTRY_W = NBYTES * 8;
  localparam logic [2:0]        LAST_B  = 3'(NBYTES - 1);
  localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_RD, S_WAIT, S_SEND, S_FIN} state_t;

  function automatic logic [7:0] entry_byte(input logic [ENTRY_W-1:0] e, input logic [2:0] sel);
    return 8'(e >> {sel, 3'b000});
  endfunction

  function automatic logic [7:0] hdr_byte(input logic [ADDR_W-1:0] c, input logic hi);
    logic [15:0] c16;
    c16 = 16'(c);
    return hi ? c16[15:8] : c16[7:0];
  endfunction

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                clr_lat_q, clr_lat_d;
  logic [1:0]          hb_q, hb_d;
  logic [2:0]          b_q, b_d;
  logic [ENTRY_W-1:0]  entry_q, entry_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_valid_q, tx_valid_d;
  logic                tx_last_q, tx_last_d;
  logic                re_q, re_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                clr_ram_q, clr_ram_d;

  logic                xfer;
  logic                last_entry;
  logic                fin;
  logic [ADDR_W-1:0]   sat_cnt;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    clr_lat_d  = clr_lat_q;
    hb_d       = hb_q;
    b_d        = b_q;
    entry_d    = entry_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    tx_last_d  = tx_last_q;
    re_d       = 1'b0;
    rd_addr_d  = rd_addr_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    clr_ram_d  = 1'b0;
    fin        = 1'b0;

    xfer       = tx_valid_q && tx_ready;
    last_entry = (idx_q == cnt_q - ONE);
    sat_cnt    = (log_count > DEPTH) ? DEPTH : log_count;

    case (state_q)
      S_IDLE: begin
        if (dump_req) begin
          cnt_d      = sat_cnt;
          clr_lat_d  = clr_after;
          idx_d      = '0;
          hb_d       = 2'd0;
          busy_d     = 1'b1;
          tx_valid_d = 1'b1;
          tx_data_d  = HDR_BYTE;
          tx_last_d  = 1'b0;
          state_d    = S_HDR;
        end
      end
      S_HDR: begin
        if (xfer) begin
          if (hb_q == 2'd2) begin
            if (cnt_q == '0) begin
              fin = 1'b1;
            end else begin
              idx_d      = '0;
              rd_addr_d  = '0;
              re_d       = 1'b1;
              tx_valid_d = 1'b0;
              state_d    = S_RD;
            end
          end else begin
            hb_d      = hb_q + 2'd1;
            tx_data_d = hdr_byte(cnt_q, hb_q[0]);
            tx_last_d = (hb_q == 2'd1) && (cnt_q == '0);
          end
        end
      end
      S_RD: state_d = S_WAIT;
      // RAM data is valid this cycle; the first byte goes out next cycle
      S_WAIT: begin
        entry_d    = ENTRY_W'(rd_data);
        tx_data_d  = rd_data[7:0];
        tx_valid_d = 1'b1;
        tx_last_d  = 1'b0;
        b_d        = 3'd0;
        state_d    = S_SEND;
      end
      S_SEND: begin
        if (xfer) begin
          if (b_q == LAST_B) begin
            if (last_entry) begin
              fin = 1'b1;
            end else begin
              idx_d      = idx_q + ONE;
              rd_addr_d  = idx_q + ONE;
              re_d       = 1'b1;
              tx_valid_d = 1'b0;
              state_d    = S_RD;
            end
          end else begin
            b_d       = b_q + 3'd1;
            tx_data_d = entry_byte(entry_q, b_q + 3'd1);
            tx_last_d = ((b_q + 3'd1) == LAST_B) && last_entry;
          end
        end
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (fin) begin
      tx_valid_d = 1'b0;
      tx_last_d  = 1'b0;
      busy_d     = 1'b0;
      done_d     = 1'b1;
      clr_ram_d  = clr_lat_q;
      state_d    = S_FIN;
    end

    // busy is low in IDLE and FIN, so abort only acts on a live dump
    if (dump_abort && busy_q) begin
      tx_valid_d = 1'b0;
      tx_last_d  = 1'b0;
      re_d       = 1'b0;
      busy_d     = 1'b0;
      done_d     = 1'b1;
      clr_ram_d  = 1'b0;
      state_d    = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      clr_lat_q  <= 1'b0;
      hb_q       <= 2'd0;
      b_q        <= 3'd0;
      entry_q    <= '0;
      tx_data_q  <= 8'd0;
      tx_valid_q <= 1'b0;
      tx_last_q  <= 1'b0;
      re_q       <= 1'b0;
      rd_addr_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      clr_ram_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      clr_lat_q  <= clr_lat_d;
      hb_q       <= hb_d;
      b_q        <= b_d;
      entry_q    <= entry_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      tx_last_q  <= tx_last_d;
      re_q       <= re_d;
      rd_addr_q  <= rd_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      clr_ram_q  <= clr_ram_d;
    end
  end

  assign re       = re_q;
  assign rd_addr  = rd_addr_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign tx_last  = tx_last_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign clr_ram  = clr_ram_q;

endmodule

// File: tb/tb_log_reader.sv
// Bench for log_reader: random RAM contents and sink backpressure, checked against
// a byte-queue model of the expected dump stream.
`timescale 1ns/1ps
module tb_log_reader;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        dump_req = 1'b0;
  logic        dump_abort = 1'b0;
  logic [15:0] log_count = 16'd0;
  logic        clr_after = 1'b0;
  logic        tx_ready = 1'b0;
  logic        re;
  logic [15:0] rd_addr;
  logic [36:0] rd_data = '0;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_last, busy, done, clr_ram;

  logic [36:0] mem [0:DEPTH-1];
  logic [7:0]  exp_q [$];
  int          checks = 0, errors = 0;
  int          exp_addr = 0, max_addr = 0, nxfer = 0;
  int          cyc = 0, hold_until = 0, hold_xfer = -1, ready_mode = 0;
  bit          held = 0, exp_clr = 0, done_seen = 0;
  bit          prev_hold = 0, prev_last = 0, abort_pend = 0, expect_done = 0, start_pend = 0;
  logic [7:0]  prev_data = 8'd0;

  log_reader dut (
    .clk(clk), .reset_n(reset_n), .dump_req(dump_req), .dump_abort(dump_abort),
    .log_count(log_count), .clr_after(clr_after), .re(re), .rd_addr(rd_addr),
    .rd_data(rd_data), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_last(tx_last), .busy(busy), .done(done), .clr_ram(clr_ram)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (re) rd_data <= mem[rd_addr[7:0]];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Sink: drives tx_ready on the falling edge
  always @(negedge clk) begin
    cyc++;
    if (!held && nxfer == hold_xfer) begin
      held = 1;
      hold_until = cyc + 10;
    end
    if (cyc < hold_until) tx_ready = 1'b0;
    else if (ready_mode == 0) tx_ready = 1'b1;
    else if (ready_mode == 1) tx_ready = cyc[0];
    else tx_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: samples between edges what the next rising edge will see
  always @(negedge clk) begin
    #1;
    if (!reset_n) begin
      prev_hold = 0; abort_pend = 0; expect_done = 0; start_pend = 0;
    end else begin
      if (start_pend) begin
        chk("busy_start", busy, 1);
        chk("hdr_valid", tx_valid, 1);
        start_pend = 0;
      end
      if (prev_hold) begin
        chk("hold_valid", tx_valid, 1);
        chk("hold_data", tx_data, prev_data);
        chk("hold_last", tx_last, prev_last);
      end
      if (abort_pend) begin
        chk("abort_valid", tx_valid, 0);
        chk("abort_done", done, 1);
        chk("abort_clr", clr_ram, 0);
        chk("abort_busy", busy, 0);
        abort_pend = 0;
        exp_q.delete();
        done_seen = 1;
      end else if (expect_done) begin
        chk("done_pulse", done, 1);
        chk("clr_ram", clr_ram, exp_clr);
        chk("busy_fin", busy, 0);
        chk("valid_fin", tx_valid, 0);
        expect_done = 0;
        done_seen = 1;
      end else begin
        if (done) chk("spurious_done", done, 0);
        if (clr_ram) chk("spurious_clr", clr_ram, 0);
      end
      if (re) begin
        chk("rd_addr", rd_addr, exp_addr);
        exp_addr++;
        if (int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
      end
      if (tx_valid && tx_ready) begin
        nxfer++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_byte: got %0h expected no byte (t=%0t)", tx_data, $time);
        end else begin
          chk("tx_data", tx_data, exp_q[0]);
          chk("tx_last", tx_last, exp_q.size() == 1);
          void'(exp_q.pop_front());
          if (exp_q.size() == 0 && !(dump_abort && busy)) expect_done = 1;
        end
      end
      if (dump_abort && busy) abort_pend = 1;
      if (dump_req && !busy && !done) start_pend = 1;
      prev_hold = tx_valid && !tx_ready && !dump_abort;
      prev_data = tx_data;
      prev_last = tx_last;
    end
  end

  task automatic build_exp(input logic [15:0] lc);
    int c;
    c = (int'(lc) > DEPTH) ? DEPTH : int'(lc);
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(c[7:0]);
    exp_q.push_back(c[15:8]);
    for (int i = 0; i < c; i++)
      for (int k = 0; k < 5; k++)
        exp_q.push_back(8'({3'b000, mem[i]} >> (8 * k)));
  endtask

  task automatic fill_mem();
    for (int i = 0; i < DEPTH; i++) mem[i] = 37'({$urandom, $urandom});
  endtask

  task automatic start_dump(input logic [15:0] lc, input bit clr, input bit also_abort);
    build_exp(lc);
    exp_clr = clr; exp_addr = 0; max_addr = 0; nxfer = 0; done_seen = 0;
    @(negedge clk);
    log_count = lc; clr_after = clr; dump_req = 1'b1; dump_abort = also_abort;
    @(negedge clk);
    dump_req = 1'b0; dump_abort = 1'b0;
    log_count = 16'($urandom); clr_after = 1'($urandom);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done_seen && n < budget) begin
      @(negedge clk);
      n++;
    end
    #2;
    chk("done_timeout", done_seen, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic run_dump(input logic [15:0] lc, input bit clr, input bit also_abort, input int budget);
    int c;
    c = (int'(lc) > DEPTH) ? DEPTH : int'(lc);
    start_dump(lc, clr, also_abort);
    wait_done(budget);
    chk("stream_drained", exp_q.size(), 0);
    chk("re_count", exp_addr, c);
  endtask

  task automatic wait_xfer(input int target, input int budget);
    int n;
    n = 0;
    while (nxfer < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("xfer_timeout", nxfer >= target, 1);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_valid"}, tx_valid, 0);
    chk({tag, "_data"}, tx_data, 0);
    chk({tag, "_last"}, tx_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_clr"}, clr_ram, 0);
    chk({tag, "_re"}, re, 0);
    chk({tag, "_addr"}, rd_addr, 0);
  endtask

  logic [7:0] lit_two [13] = '{8'hA5, 8'h02, 8'h00, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01,
                               8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};

  initial begin
    fill_mem();
    repeat (3) @(negedge clk);
    #1;
    chk_outputs_zero("reset");
    reset_n = 1'b1;

    // Empty log
    ready_mode = 0;
    build_exp(16'd0);
    chk("model_empty_len", exp_q.size(), 3);
    chk("model_empty_b0", exp_q[0], 8'hA5);
    chk("model_empty_b1", exp_q[1], 8'h00);
    chk("model_empty_b2", exp_q[2], 8'h00);
    run_dump(16'd0, 1'b0, 1'b0, 100);

    // Two known entries
    mem[0] = 37'h1_2345_6789;
    mem[1] = 37'h0_0000_00FF;
    build_exp(16'd2);
    chk("model_two_len", exp_q.size(), 13);
    for (int i = 0; i < 13; i++) chk("model_two_byte", exp_q[i], lit_two[i]);
    run_dump(16'd2, 1'b1, 1'b0, 200);
    chk("two_max_addr", max_addr, 1);

    // Backpressure: toggling ready plus a 10-cycle stall in the middle of entry 0
    ready_mode = 1;
    hold_xfer = 5;
    run_dump(16'd2, 1'b1, 1'b0, 400);

    // Saturation
    ready_mode = 0;
    fill_mem();
    build_exp(16'h0300);
    chk("model_sat_b1", exp_q[1], 8'h00);
    chk("model_sat_b2", exp_q[2], 8'h01);
    run_dump(16'h0300, 1'b0, 1'b0, 2500);
    chk("sat_max_addr", max_addr, 255);
    chk("sat_bytes", nxfer, 1283);

    // Random dumps with random backpressure; one starts with a simultaneous abort
    ready_mode = 2;
    for (int i = 0; i < 6; i++) begin
      fill_mem();
      run_dump(16'($urandom_range(0, 24)), 1'($urandom), i == 2, 2000);
    end

    // Abort during byte 2 of entry 5
    ready_mode = 0;
    start_dump(16'd8, 1'b1, 1'b0);
    wait_xfer(30, 300);
    dump_abort = 1'b1;
    @(negedge clk);
    dump_abort = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    chk("abort_done_seen", done_seen, 1);
    chk("abort_bytes", nxfer, 31);
    run_dump(16'd3, 1'b1, 1'b0, 300);

    // Asynchronous reset in the middle of SEND
    start_dump(16'd6, 1'b1, 1'b0);
    wait_xfer(12, 300);
    @(negedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk_outputs_zero("areset");
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    run_dump(16'd4, 1'b1, 1'b0, 300);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
